fmanormpipe: RTL

Two-stage pipelined normalization stage that sits directly downstream of the FMA leading-zero anticipator. It takes the sum magnitude plus the anticipated shift count, clamps the shift for subnormal results, left-shifts, applies the one-bit LZA correction, and adjusts the exponent. Results are delivered over a valid/ready handshake to the rounding stage.

---
 rtl/fmanormpipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fmanormpipe.sv
// Post-LZA normalization: clamps the anticipated shift for subnormal results,
// left-shifts the sum magnitude, applies the 1-bit LZA fix-up and adjusts the exponent.
module fmanormpipe #(
  parameter int WIDTH = 16,
  parameter int NE    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           InValid,
  output logic                           InReady,
  input  logic [WIDTH-1:0]               Sm,
  input  logic [$clog2(WIDTH+1)-1:0]     SCnt,
  input  logic signed [NE+1:0]           Se,
  input  logic                           Flush,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic [WIDTH-1:0]               Mf,
  output logic signed [NE+1:0]           Me,
  output logic                           Zero,
  output logic                           LzaCorr
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int EW = NE + 2;
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic signed [EW-1:0] EONE  = EW'(1);

  // Smallest exponent a normalized result may take is 1; the shift may not push below it.
  function automatic logic signed [EW-1:0] f_lim(input logic signed [EW-1:0] se);
    return (se > EZERO) ? (se - EONE) : EZERO;
  endfunction

  function automatic logic signed [EW-1:0] f_ext(input logic [CW-1:0] v);
    return signed'({{(EW-CW){1'b0}}, v});
  endfunction

  function automatic logic [CW-1:0] f_clamp_sh(input logic [CW-1:0] scnt,
                                               input logic signed [EW-1:0] lim);
    return (f_ext(scnt) > lim) ? lim[CW-1:0] : scnt;
  endfunction

  logic                    w_adv2;
  logic                    w_acc;
  logic signed [EW-1:0]    w_lim;
  logic                    w_clamp;
  logic [CW-1:0]           w_sh;
  logic                    w_room;
  logic                    w_zero;

  logic                    r_vld_p1;
  logic [WIDTH-1:0]        r_sm_p1;
  logic signed [EW-1:0]    r_se_p1;
  logic [CW-1:0]           r_sh_p1;
  logic                    r_clamp_p1;
  logic                    r_room_p1;
  logic                    r_zero_p1;

  logic [WIDTH-1:0]        w_t;
  logic                    w_corr;
  logic [WIDTH-1:0]        w_mf;
  logic signed [EW-1:0]    w_me;

  logic                    r_vld_p2;
  logic [WIDTH-1:0]        r_mf_p2;
  logic signed [EW-1:0]    r_me_p2;
  logic                    r_zero_p2;
  logic                    r_corr_p2;

  assign w_adv2  = r_vld_p1 & (~r_vld_p2 | OutReady);
  assign InReady = (~r_vld_p1 | w_adv2) & ~Flush;
  assign w_acc   = InValid & InReady;

  assign w_lim   = f_lim(Se);
  assign w_clamp = f_ext(SCnt) > w_lim;
  assign w_sh    = f_clamp_sh(SCnt, w_lim);
  assign w_room  = (f_ext(w_sh) + EONE) <= w_lim;
  assign w_zero  = (Sm == '0);

  // ---- S1: shift amount resolved, operand latched ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_sm_p1    <= '0;
      r_se_p1    <= '0;
      r_sh_p1    <= '0;
      r_clamp_p1 <= 1'b0;
      r_room_p1  <= 1'b0;
      r_zero_p1  <= 1'b0;
    end else begin
      if (Flush)
        r_vld_p1 <= 1'b0;
      else if (w_acc)
        r_vld_p1 <= 1'b1;
      else if (w_adv2)
        r_vld_p1 <= 1'b0;
      if (w_acc) begin
        r_sm_p1    <= Sm;
        r_se_p1    <= Se;
        r_sh_p1    <= w_sh;
        r_clamp_p1 <= w_clamp;
        r_room_p1  <= w_room;
        r_zero_p1  <= w_zero;
      end
    end
  end

  // The correction only fires when the extra shift still leaves the exponent >= 1.
  assign w_t    = r_sm_p1 << r_sh_p1;
  assign w_corr = ~r_zero_p1 & ~w_t[WIDTH-1] & ~r_clamp_p1 & r_room_p1;
  assign w_mf   = r_zero_p1 ? '0 : (w_corr ? (w_t << 1) : w_t);
  assign w_me   = r_zero_p1 ? EZERO
                            : (r_se_p1 - f_ext(r_sh_p1) - (w_corr ? EONE : EZERO));

  // ---- S2: normalized result held for the rounding stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2  <= 1'b0;
      r_mf_p2   <= '0;
      r_me_p2   <= '0;
      r_zero_p2 <= 1'b0;
      r_corr_p2 <= 1'b0;
    end else begin
      if (Flush)
        r_vld_p2 <= 1'b0;
      else if (w_adv2)
        r_vld_p2 <= 1'b1;
      else if (OutReady)
        r_vld_p2 <= 1'b0;
      if (w_adv2 && !Flush) begin
        r_mf_p2   <= w_mf;
        r_me_p2   <= w_me;
        r_zero_p2 <= r_zero_p1;
        r_corr_p2 <= w_corr;
      end
    end
  end

  assign OutValid = r_vld_p2;
  assign Mf       = r_mf_p2;
  assign Me       = r_me_p2;
  assign Zero     = r_zero_p2;
  assign LzaCorr  = r_corr_p2;

endmodule
